// File: rtl/impl_amo_adapter.sv
// impl_amo_adapter: bridges a 32-bit core data port (with RISC-V AMO tags) onto a
// 64-bit-word memory bank that executes atomics in place.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   data_req_i/gnt_o       core request handshake (push into request FIFO)
//   data_addr_i            byte address; [2] selects the 32-bit half of the bank word
//   data_we_i/be_i/wdata_i core write enable, byte enables, write data
//   data_atop_i            [5] = AMO valid, [4:0] = RISC-V funct5
//   data_rvalid_o/rdata_o  in-order response, one per bank transaction
//   bank_req_o/gnt_i       bank handshake, driven from the FIFO head
//   bank_add_o/amo_o/wen_o/wdata_o/be_o  bank command fields
//   bank_rdata_i           bank read data, valid the cycle after a granted request
module impl_amo_adapter #(
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned FifoDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // core side
  input  logic                    data_req_i,
  input  logic [31:0]             data_addr_i,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  input  logic [31:0]             data_wdata_i,
  input  logic [5:0]              data_atop_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [31:0]             data_rdata_o,
  // bank side
  output logic                    bank_req_o,
  output logic [AddrMemWidth-1:0] bank_add_o,
  output logic [3:0]              bank_amo_o,
  output logic                    bank_wen_o,
  output logic [63:0]             bank_wdata_o,
  output logic [7:0]              bank_be_o,
  input  logic                    bank_gnt_i,
  input  logic [63:0]             bank_rdata_i
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef enum logic [0:0] {StIssue, StAmoHold} state_e;

  localparam logic [3:0] AmoNone = 4'h0;
  localparam logic [3:0] AmoLr   = 4'hB;

  // Bank AMO encoding from the RISC-V funct5; anything unknown degrades to a plain access.
  function automatic logic [3:0] amo_map(input logic [5:0] atop);
    logic [3:0] code;
    code = AmoNone;
    if (atop[5]) begin
      case (atop[4:0])
        5'b00001: code = 4'h1; // swap
        5'b00000: code = 4'h2; // add
        5'b01100: code = 4'h3; // and
        5'b01000: code = 4'h4; // or
        5'b00100: code = 4'h5; // xor
        5'b10100: code = 4'h6; // max
        5'b11100: code = 4'h7; // maxu
        5'b10000: code = 4'h8; // min
        5'b11000: code = 4'h9; // minu
        5'b00010: code = 4'hB; // lr
        5'b00011: code = 4'hC; // sc
        default:  code = AmoNone;
      endcase
    end
    return code;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(FifoDepth - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  // Request FIFO storage
  logic [AddrMemWidth-1:0] add_mem   [FifoDepth];
  logic                    upper_mem [FifoDepth];
  logic [3:0]              amo_mem   [FifoDepth];
  logic                    we_mem    [FifoDepth];
  logic [3:0]              be_mem    [FifoDepth];
  logic [31:0]             wdata_mem [FifoDepth];

  ptr_t            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  state_e          state_q;
  logic            rvalid_q, resp_upper_q;

  logic fifo_full, fifo_empty, push, pop;
  logic head_upper, head_we, head_plain;
  logic [3:0] head_amo, head_be;
  logic [31:0] head_wdata;

  // Zero-extend so the word address slice is legal for any AddrMemWidth.
  logic [AddrMemWidth+2:0] addr_ext;
  logic                    unused_addr;

  assign addr_ext    = (AddrMemWidth + 3)'(data_addr_i);
  assign unused_addr = ^addr_ext[1:0];

  assign fifo_full  = (cnt_q == CntW'(FifoDepth));
  assign fifo_empty = (cnt_q == '0);

  assign data_gnt_o = ~fifo_full;
  assign push       = data_req_i & ~fifo_full;
  assign bank_req_o = ~fifo_empty & (state_q == StIssue);
  assign pop        = bank_req_o & bank_gnt_i;

  assign head_upper = upper_mem[rd_ptr_q];
  assign head_amo   = amo_mem[rd_ptr_q];
  assign head_we    = we_mem[rd_ptr_q];
  assign head_be    = be_mem[rd_ptr_q];
  assign head_wdata = wdata_mem[rd_ptr_q];
  // Plain accesses and LR are single bank cycles; every other AMO needs a write-back cycle.
  assign head_plain = (head_amo == AmoNone) | (head_amo == AmoLr);

  assign bank_add_o   = add_mem[rd_ptr_q];
  assign bank_amo_o   = head_amo;
  assign bank_wen_o   = head_plain ? head_we : 1'b1;
  assign bank_wdata_o = {head_wdata, head_wdata};
  assign bank_be_o    = head_upper ? {head_be, 4'b0000} : {4'b0000, head_be};

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rvalid_q ? (resp_upper_q ? bank_rdata_i[63:32] : bank_rdata_i[31:0])
                                  : 32'h0;

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      add_mem[wr_ptr_q]   <= addr_ext[AddrMemWidth+2:3];
      upper_mem[wr_ptr_q] <= data_addr_i[2];
      amo_mem[wr_ptr_q]   <= amo_map(data_atop_i);
      we_mem[wr_ptr_q]    <= data_we_i;
      be_mem[wr_ptr_q]    <= data_be_i;
      wdata_mem[wr_ptr_q] <= data_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!push && pop) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  // Issue FSM plus the response register that tracks the last popped request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIssue;
      rvalid_q     <= 1'b0;
      resp_upper_q <= 1'b0;
    end else begin
      rvalid_q <= pop;
      if (pop) begin
        resp_upper_q <= head_upper;
      end
      unique case (state_q)
        StIssue:   if (pop && !head_plain) state_q <= StAmoHold;
        StAmoHold: state_q <= StIssue;
        default:   state_q <= StIssue;
      endcase
    end
  end

endmodule

// File: tb/tb_impl_amo_adapter.sv
module tb_impl_amo_adapter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [5:0]  data_atop_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        bank_req_o;
  logic [31:0] bank_add_o;
  logic [3:0]  bank_amo_o;
  logic        bank_wen_o;
  logic [63:0] bank_wdata_o;
  logic [7:0]  bank_be_o;
  logic        bank_gnt_i;
  logic [63:0] bank_rdata_i = '0;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  int base;
  logic [31:0] sb[$];
  logic [63:0] mem[16];

  impl_amo_adapter #(.AddrMemWidth(32), .FifoDepth(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_req_i   (data_req_i),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_atop_i  (data_atop_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .bank_req_o   (bank_req_o),
    .bank_add_o   (bank_add_o),
    .bank_amo_o   (bank_amo_o),
    .bank_wen_o   (bank_wen_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_be_o    (bank_be_o),
    .bank_gnt_i   (bank_gnt_i),
    .bank_rdata_i (bank_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bank model: read data appears the cycle after a granted request.
  always @(posedge clk_i) begin
    if (bank_req_o && bank_gnt_i) bank_rdata_i <= mem[bank_add_o[3:0]];
  end

  // Response monitor: every rvalid must match the oldest outstanding request.
  always @(negedge clk_i) begin
    if (rst_ni && data_rvalid_o === 1'b1) begin
      rv_count++;
      if (sb.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
      else check("rdata_order", {32'h0, data_rdata_o}, {32'h0, sb.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [5:0] atop);
    logic [3:0] idx;
    data_req_i   = 1'b1;
    data_addr_i  = addr;
    data_we_i    = we;
    data_be_i    = be;
    data_wdata_i = wdata;
    data_atop_i  = atop;
    for (int i = 0; i < 40 && data_gnt_o !== 1'b1; i++) cyc();
    check("grant_timeout", {63'h0, data_gnt_o}, 64'd1);
    idx = addr[6:3];
    sb.push_back(addr[2] ? mem[idx][63:32] : mem[idx][31:0]);
    cyc();
    data_req_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {8'hA0, 24'(i), 8'hB0, 24'(i)};
    mem[2] = 64'h1111_2222_3333_4444;
    rst_ni = 1'b0; data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0;
    data_be_i = '0; data_wdata_i = '0; data_atop_i = '0; bank_gnt_i = 1'b0;
    repeat (2) cyc();
    check("rst_gnt", {63'h0, data_gnt_o}, 64'd1);
    check("rst_bank_req", {63'h0, bank_req_o}, 64'd0);
    check("rst_rvalid", {63'h0, data_rvalid_o}, 64'd0);
    check("rst_rdata", {32'h0, data_rdata_o}, 64'd0);
    rst_ni = 1'b1;
    cyc();

    // Plain read, minimum latency
    bank_gnt_i = 1'b1;
    issue(32'h14, 1'b0, 4'hF, 32'h0, 6'h00);
    check("rd_bank_req", {63'h0, bank_req_o}, 64'd1);
    check("rd_bank_add", {32'h0, bank_add_o}, 64'd2);
    check("rd_bank_be", {56'h0, bank_be_o}, 64'hF0);
    check("rd_bank_amo", {60'h0, bank_amo_o}, 64'd0);
    check("rd_bank_wen", {63'h0, bank_wen_o}, 64'd0);
    cyc();
    check("rd_rvalid", {63'h0, data_rvalid_o}, 64'd1);
    check("rd_rdata", {32'h0, data_rdata_o}, 64'h1111_2222);
    cyc();
    check("rd_rvalid_low", {63'h0, data_rvalid_o}, 64'd0);
    check("rd_rdata_zero", {32'h0, data_rdata_o}, 64'd0);

    // AMO add followed by a queued plain read
    bank_gnt_i = 1'b0;
    issue(32'h8, 1'b0, 4'hF, 32'h5, 6'b100000);
    issue(32'h18, 1'b0, 4'hF, 32'h0, 6'h00);
    check("add_full_gnt", {63'h0, data_gnt_o}, 64'd0);
    check("add_bank_add", {32'h0, bank_add_o}, 64'd1);
    check("add_bank_amo", {60'h0, bank_amo_o}, 64'd2);
    check("add_bank_wen", {63'h0, bank_wen_o}, 64'd1);
    check("add_bank_wdata", bank_wdata_o, 64'h0000_0005_0000_0005);
    check("add_bank_be", {56'h0, bank_be_o}, 64'h0F);
    bank_gnt_i = 1'b1;
    cyc();
    check("add_hold_req", {63'h0, bank_req_o}, 64'd0);
    check("add_rvalid", {63'h0, data_rvalid_o}, 64'd1);
    cyc();
    check("add_next_req", {63'h0, bank_req_o}, 64'd1);
    check("add_next_add", {32'h0, bank_add_o}, 64'd3);
    cyc();
    check("add_drained", {63'h0, bank_req_o}, 64'd0);
    cyc();

    // LR then SC to the same word
    bank_gnt_i = 1'b0;
    issue(32'h20, 1'b0, 4'hF, 32'h0, 6'b100010);
    issue(32'h20, 1'b1, 4'hF, 32'hDEAD, 6'b100011);
    check("lr_amo", {60'h0, bank_amo_o}, 64'hB);
    check("lr_wen", {63'h0, bank_wen_o}, 64'd0);
    bank_gnt_i = 1'b1;
    cyc();
    check("lr_no_hold", {63'h0, bank_req_o}, 64'd1);
    check("sc_amo", {60'h0, bank_amo_o}, 64'hC);
    check("sc_wen", {63'h0, bank_wen_o}, 64'd1);
    cyc();
    check("sc_hold", {63'h0, bank_req_o}, 64'd0);
    repeat (2) cyc();

    // Backpressure: third request waits for a free slot
    bank_gnt_i = 1'b0;
    base = rv_count;
    issue(32'h2C, 1'b0, 4'hF, 32'h0, 6'h00);
    issue(32'h30, 1'b1, 4'h3, 32'h1234, 6'h00);
    check("bp_gnt_drop", {63'h0, data_gnt_o}, 64'd0);
    bank_gnt_i = 1'b1;
    issue(32'h3C, 1'b0, 4'hF, 32'h0, 6'h00);
    repeat (4) cyc();
    check("bp_rvalids", 64'(rv_count - base), 64'd3);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back plain traffic at one request per cycle
    base = rv_count;
    issue(32'h40, 1'b0, 4'hF, 32'h0, 6'h00);
    issue(32'h4C, 1'b0, 4'hF, 32'h0, 6'h00);
    issue(32'h50, 1'b0, 4'hF, 32'h0, 6'h00);
    issue(32'h5C, 1'b0, 4'hF, 32'h0, 6'h00);
    cyc();
    check("tput_3", 64'(rv_count - base), 64'd3);
    cyc();
    check("tput_4", 64'(rv_count - base), 64'd4);
    repeat (2) cyc();

    // Reset with queued and pending requests
    bank_gnt_i = 1'b0;
    issue(32'h60, 1'b0, 4'hF, 32'h0, 6'h00);
    issue(32'h64, 1'b0, 4'hF, 32'h0, 6'h00);
    bank_gnt_i = 1'b1;
    cyc();
    check("pre_rst_rvalid", {63'h0, data_rvalid_o}, 64'd1);
    base = rv_count;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_rvalid", {63'h0, data_rvalid_o}, 64'd0);
    check("mid_rst_req", {63'h0, bank_req_o}, 64'd0);
    check("mid_rst_gnt", {63'h0, data_gnt_o}, 64'd1);
    check("mid_rst_rdata", {32'h0, data_rdata_o}, 64'd0);
    repeat (2) cyc();
    rst_ni = 1'b1;
    repeat (3) cyc();
    check("post_rst_no_rvalid", 64'(rv_count - base), 64'd0);
    check("post_rst_req", {63'h0, bank_req_o}, 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
